// File: rtl/plab4_net_domain_scheduler_tp_pkg.sv
//------------------------------------------------------------------------
// plab4_net_domain_scheduler_tp_pkg
//------------------------------------------------------------------------
// Shared definitions for the timing-protected domain scheduler.
//  - cfg_msg field macros: {len_d1, len_d0}, with len_d0 in the low field.
//    They expand in terms of p_slot_nbits, so they are only usable inside
//    a module that has that parameter.
//  - Clamp-minimum macro. Every slot needs at least one active cycle, so
//    the smallest legal length is p_dead_cycles+1.
//  - The slot-phase enum (ACTIVE / DEAD) exposed by the slot counter.
//  - A generic length clamp helper.
//------------------------------------------------------------------------

`ifndef PLAB4_NET_SCHED_MSGS
`define PLAB4_NET_SCHED_MSGS
`define PLAB4_NET_SCHED_CFG_LEN_D0_FIELD (p_slot_nbits-1):0
`define PLAB4_NET_SCHED_CFG_LEN_D1_FIELD (2*p_slot_nbits-1):p_slot_nbits
`define PLAB4_NET_SCHED_CLAMP_MIN (p_dead_cycles+1)
`endif

package plab4_net_domain_scheduler_tp_pkg;

  // Phase of the current slot. In ACTIVE the terminals may inject. In DEAD
  // injection is blocked so in-flight traffic drains before the switch.
  typedef enum logic {
    SLOT_ACTIVE = 1'b0,
    SLOT_DEAD   = 1'b1
  } slot_state_e;

  // Raises a requested slot length to the minimum legal length.
  function automatic logic [31:0] clamp_len(input logic [31:0] len,
                                            input logic [31:0] min_len);
    return (len < min_len) ? min_len : len;
  endfunction

endpackage

// File: rtl/plab4_net_domain_scheduler_tp_slotcnt.sv
//------------------------------------------------------------------------
// plab4_net_DomainSlotCounter
//------------------------------------------------------------------------
// Counts cycles within the current slot and flags the slot boundary and
// the active (injection) window.
//
// Ports:
//   clk           clock
//   reset         asynchronous active-high reset; clears the counter
//   len_i         length L of the current slot (already clamped, >= dead+1)
//   slot_cnt_o    cycle index within the slot, 0 .. L-1
//   boundary_o    1 on the last cycle of the slot (slot_cnt == L-1)
//   slot_active_o 1 while slot_cnt < L - p_dead_cycles
//   state_o       ACTIVE/DEAD view of slot_active_o, for debug and checkers
//------------------------------------------------------------------------

module plab4_net_DomainSlotCounter
  import plab4_net_domain_scheduler_tp_pkg::*;
#(
  parameter int p_slot_nbits  = 8,
  parameter int p_dead_cycles = 1
)(
  input  logic                    clk,
  input  logic                    reset,
  input  logic [p_slot_nbits-1:0] len_i,
  output logic [p_slot_nbits-1:0] slot_cnt_o,
  output logic                    boundary_o,
  output logic                    slot_active_o,
  output slot_state_e             state_o
);

  localparam logic [p_slot_nbits-1:0] c_one  = p_slot_nbits'(1);
  localparam logic [p_slot_nbits-1:0] c_dead = p_slot_nbits'(p_dead_cycles);

  logic [p_slot_nbits-1:0] slot_cnt_q;
  logic [p_slot_nbits-1:0] slot_cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) slot_cnt_q <= '0;
    else       slot_cnt_q <= slot_cnt_d;
  end

  // The length only changes on a boundary, when the counter returns to 0,
  // so slot_cnt_q never overtakes L-1. The clamp guarantees that L-dead
  // cannot underflow at p_slot_nbits width.
  always_comb begin
    boundary_o    = (slot_cnt_q == (len_i - c_one));
    slot_cnt_d    = boundary_o ? '0 : (slot_cnt_q + c_one);
    slot_active_o = (slot_cnt_q < (len_i - c_dead));
    state_o       = slot_active_o ? SLOT_ACTIVE : SLOT_DEAD;
  end

  assign slot_cnt_o = slot_cnt_q;

endmodule

// File: rtl/plab4_net_domain_scheduler_tp.sv
//------------------------------------------------------------------------
// plab4_net_domain_scheduler_tp
//------------------------------------------------------------------------
// Time-division scheduler for the timing-protected ring. It alternates
// domain 0 and domain 1 in fixed-length slots and blanks the trailing
// p_dead_cycles of every slot. Slot lengths come from active registers
// that reload from pending registers only at an epoch boundary, which is
// the end of a domain-1 slot. The schedule therefore never depends on
// run-time traffic.
//
// Ports:
//   clk, reset        clock; asynchronous active-high reset
//   cfg_val/cfg_rdy   config write handshake. A write transfers on a cycle
//                     where cfg_val && cfg_rdy at the rising clk edge.
//                     cfg_rdy is always 1.
//   cfg_msg           {len_d1, len_d0}; written into the pending lengths
//   domain            current security domain (router domain select)
//   slot_active       1 = injection window, 0 = dead time
//   inject_en_d0/d1   per-domain terminal injection enables
//   slot_cnt          cycle index within the current slot
//   epoch_cnt         completed d0+d1 epochs, wraps
//   slot_state        ACTIVE/DEAD phase of the slot (debug view)
// Every output comes from registers only; cfg_* reach only pending state.
//------------------------------------------------------------------------

module plab4_net_domain_scheduler_tp
  import plab4_net_domain_scheduler_tp_pkg::*;
#(
  parameter int p_slot_nbits     = 8,
  parameter int p_default_len_d0 = 4,
  parameter int p_default_len_d1 = 4,
  parameter int p_dead_cycles    = 1,
  parameter int p_epoch_nbits    = 16
)(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cfg_val,
  output logic                      cfg_rdy,
  input  logic [2*p_slot_nbits-1:0] cfg_msg,
  output logic                      domain,
  output logic                      slot_active,
  output logic                      inject_en_d0,
  output logic                      inject_en_d1,
  output logic [p_slot_nbits-1:0]   slot_cnt,
  output logic [p_epoch_nbits-1:0]  epoch_cnt,
  output slot_state_e               slot_state
);

  localparam int c_clamp_min = `PLAB4_NET_SCHED_CLAMP_MIN;
  localparam int c_def_d0 = (p_default_len_d0 < c_clamp_min) ? c_clamp_min
                                                             : p_default_len_d0;
  localparam int c_def_d1 = (p_default_len_d1 < c_clamp_min) ? c_clamp_min
                                                             : p_default_len_d1;
  localparam logic [p_slot_nbits-1:0] c_rst_len_d0 = p_slot_nbits'(c_def_d0);
  localparam logic [p_slot_nbits-1:0] c_rst_len_d1 = p_slot_nbits'(c_def_d1);

  function automatic logic [p_slot_nbits-1:0] clamp(input logic [p_slot_nbits-1:0] len);
    logic [31:0] v;
    v = clamp_len(32'(len), 32'(c_clamp_min));
    return v[p_slot_nbits-1:0];
  endfunction

  logic                     domain_q,   domain_d;
  logic [p_epoch_nbits-1:0] epoch_q,    epoch_d;
  logic [p_slot_nbits-1:0]  len_d0_q,   len_d0_d;
  logic [p_slot_nbits-1:0]  len_d1_q,   len_d1_d;
  logic [p_slot_nbits-1:0]  pend_d0_q,  pend_d0_d;
  logic [p_slot_nbits-1:0]  pend_d1_q,  pend_d1_d;

  logic [p_slot_nbits-1:0]  cur_len;
  logic                     boundary;
  logic                     cfg_fire;
  logic                     epoch_end;

  assign cfg_rdy  = 1'b1;
  assign cfg_fire = cfg_val && cfg_rdy;
  assign cur_len  = domain_q ? len_d1_q : len_d0_q;

  plab4_net_DomainSlotCounter #(
    .p_slot_nbits  (p_slot_nbits),
    .p_dead_cycles (p_dead_cycles)
  ) slot_counter (
    .clk           (clk),
    .reset         (reset),
    .len_i         (cur_len),
    .slot_cnt_o    (slot_cnt),
    .boundary_o    (boundary),
    .slot_active_o (slot_active),
    .state_o       (slot_state)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      domain_q  <= 1'b0;
      epoch_q   <= '0;
      len_d0_q  <= c_rst_len_d0;
      len_d1_q  <= c_rst_len_d1;
      pend_d0_q <= c_rst_len_d0;
      pend_d1_q <= c_rst_len_d1;
    end else begin
      domain_q  <= domain_d;
      epoch_q   <= epoch_d;
      len_d0_q  <= len_d0_d;
      len_d1_q  <= len_d1_d;
      pend_d0_q <= pend_d0_d;
      pend_d1_q <= pend_d1_d;
    end
  end

  // An epoch ends on the boundary of a domain-1 slot. The active lengths
  // load the pending registers as they stood before this edge. A config
  // write landing on the same edge only updates pending, so it takes effect
  // at the following epoch.
  always_comb begin
    epoch_end = boundary && domain_q;
    domain_d  = domain_q ^ boundary;
    epoch_d   = epoch_end ? (epoch_q + p_epoch_nbits'(1)) : epoch_q;
    len_d0_d  = epoch_end ? pend_d0_q : len_d0_q;
    len_d1_d  = epoch_end ? pend_d1_q : len_d1_q;
    pend_d0_d = pend_d0_q;
    pend_d1_d = pend_d1_q;
    if (cfg_fire) begin
      pend_d0_d = clamp(cfg_msg[`PLAB4_NET_SCHED_CFG_LEN_D0_FIELD]);
      pend_d1_d = clamp(cfg_msg[`PLAB4_NET_SCHED_CFG_LEN_D1_FIELD]);
    end
  end

  assign domain       = domain_q;
  assign epoch_cnt    = epoch_q;
  assign inject_en_d0 = slot_active && !domain_q;
  assign inject_en_d1 = slot_active &&  domain_q;

endmodule

// File: tb/tb_plab4_net_domain_scheduler_tp.sv
//------------------------------------------------------------------------
// tb_plab4_net_domain_scheduler_tp
//------------------------------------------------------------------------
// Directed bench for the domain scheduler. "Cycle n" means the n-th clock
// period after reset release; cycle 0 shows the reset state. Outputs are
// sampled at the falling edge. Inputs are driven right after the falling
// edge. A second instance with a 2-bit epoch counter runs alongside the
// first with config idle to show the epoch counter wrapping.
//------------------------------------------------------------------------

module tb_plab4_net_domain_scheduler_tp
  import plab4_net_domain_scheduler_tp_pkg::*;
;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        cfg_val;
  logic        cfg_rdy;
  logic [15:0] cfg_msg;
  logic        domain, slot_active, inject_en_d0, inject_en_d1;
  logic [7:0]  slot_cnt;
  logic [15:0] epoch_cnt;
  slot_state_e slot_state;

  logic        cfg_val2;
  logic        cfg_rdy2;
  logic [15:0] cfg_msg2;
  logic        domain2, slot_active2, inj0_2, inj1_2;
  logic [7:0]  slot_cnt2;
  logic [1:0]  epoch_cnt2;
  slot_state_e slot_state2;

  plab4_net_domain_scheduler_tp dut (
    .clk          (clk),
    .reset        (reset),
    .cfg_val      (cfg_val),
    .cfg_rdy      (cfg_rdy),
    .cfg_msg      (cfg_msg),
    .domain       (domain),
    .slot_active  (slot_active),
    .inject_en_d0 (inject_en_d0),
    .inject_en_d1 (inject_en_d1),
    .slot_cnt     (slot_cnt),
    .epoch_cnt    (epoch_cnt),
    .slot_state   (slot_state)
  );

  plab4_net_domain_scheduler_tp #(.p_epoch_nbits(2)) dut2 (
    .clk          (clk),
    .reset        (reset),
    .cfg_val      (cfg_val2),
    .cfg_rdy      (cfg_rdy2),
    .cfg_msg      (cfg_msg2),
    .domain       (domain2),
    .slot_active  (slot_active2),
    .inject_en_d0 (inj0_2),
    .inject_en_d1 (inj1_2),
    .slot_cnt     (slot_cnt2),
    .epoch_cnt    (epoch_cnt2),
    .slot_state   (slot_state2)
  );

  // ---------------- scoreboard ----------------
  int n_chk = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Checks the full per-cycle view against expected domain/active/epoch.
  task automatic chk_pat(input string tag, input logic exp_dom, input logic exp_act,
                         input int exp_epoch);
    logic [1:0] exp_st;
    exp_st = exp_act ? 2'd0 : 2'd1;
    check({tag, ".domain"}, 32'(domain), 32'(exp_dom));
    check({tag, ".active"}, 32'(slot_active), 32'(exp_act));
    check({tag, ".inj0"}, 32'(inject_en_d0), 32'(exp_act && !exp_dom));
    check({tag, ".inj1"}, 32'(inject_en_d1), 32'(exp_act && exp_dom));
    check({tag, ".epoch"}, 32'(epoch_cnt), 32'(exp_epoch));
    check({tag, ".state"}, 32'(slot_state), 32'(exp_st));
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    cfg_val = 1'b0;
    cfg_msg = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
  endtask

  // Presents one config write for one clock; it ends one cycle later.
  task automatic cfg_write(input logic [7:0] d1, input logic [7:0] d0);
    cfg_val = 1'b1;
    cfg_msg = {d1, d0};
    tick();
    cfg_val = 1'b0;
  endtask

  // Default 4/4 schedule: bit i = cycle i within an 8-cycle epoch.
  logic [7:0]  dflt_dom = 8'b1111_0000;
  logic [3:0]  dflt_act = 4'b0111;
  // {6,2} from cycle 8: bit i = cycle i, 0..17.
  logic [17:0] t2_dom   = 18'b00_111111_00_1111_0000;
  logic [17:0] t2_act   = 18'b01_011111_01_0111_0111;

  // ---------------- stimulus ----------------
  initial begin
    reset    = 1'b1;
    cfg_val  = 1'b0;
    cfg_msg  = '0;
    cfg_val2 = 1'b0;
    cfg_msg2 = '0;

    // Reset state, observed while reset is held.
    @(negedge clk);
    chk_pat("rst", 1'b0, 1'b1, 0);
    check("rst.slot_cnt", 32'(slot_cnt), 32'd0);
    check("rst.cfg_rdy", 32'(cfg_rdy), 32'd1);

    // Default schedule, plus the wrap of the 2-bit epoch counter in dut2.
    do_reset();
    for (int i = 0; i <= 36; i++) begin
      if (i < 16) begin
        chk_pat("dflt", dflt_dom[i % 8], dflt_act[i % 4], i / 8);
        check("dflt.slot_cnt", 32'(slot_cnt), 32'(i % 4));
      end
      if (i == 24) check("ep2.epoch24", 32'(epoch_cnt2), 32'd3);
      if (i == 32) begin
        check("ep2.epoch32_wrap", 32'(epoch_cnt2), 32'd0);
        check("ep2.domain32", 32'(domain2), 32'd0);
        check("dflt.epoch32", 32'(epoch_cnt), 32'd4);
      end
      if (i == 36) check("ep2.domain36", 32'(domain2), 32'd1);
      tick();
    end

    // Write {6,2} mid-epoch at cycle 2. It takes effect at cycle 8.
    do_reset();
    for (int i = 0; i <= 17; i++) begin
      chk_pat("cfg62", t2_dom[i], t2_act[i], (i < 8) ? 0 : ((i < 16) ? 1 : 2));
      if (i == 15) check("cfg62.slot_cnt15", 32'(slot_cnt), 32'd5);
      if (i == 2) cfg_write(8'd6, 8'd2);
      else        tick();
    end

    // Write on the epoch boundary (cycle 7, domain 1, slot_cnt 3): the next
    // epoch keeps 4/4 and {6,2} starts at cycle 16.
    do_reset();
    for (int i = 0; i <= 24; i++) begin
      logic d, a;
      int   e;
      if (i < 16) begin
        d = dflt_dom[i % 8]; a = dflt_act[i % 4]; e = i / 8;
      end else if (i < 18) begin
        d = 1'b0; a = (i == 16); e = 2;
      end else if (i < 24) begin
        d = 1'b1; a = (i != 23); e = 2;
      end else begin
        d = 1'b0; a = 1'b1; e = 3;
      end
      chk_pat("cfgbnd", d, a, e);
      if (i == 7) begin
        check("cfgbnd.slot_cnt7", 32'(slot_cnt), 32'd3);
        cfg_write(8'd6, 8'd2);
      end else begin
        tick();
      end
    end

    // Lengths below the minimum: len_d0=0, len_d1=1 are both stored as 2.
    do_reset();
    for (int i = 0; i <= 13; i++) begin
      logic d, a;
      int   e;
      if (i < 8) begin
        d = dflt_dom[i % 8]; a = dflt_act[i % 4]; e = 0;
      end else begin
        d = ((i - 8) % 4) >= 2; a = (i % 2) == 0; e = (i < 12) ? 1 : 2;
      end
      chk_pat("clamp", d, a, e);
      if (i == 9)  check("clamp.slot_cnt9", 32'(slot_cnt), 32'd1);
      if (i == 10) check("clamp.slot_cnt10", 32'(slot_cnt), 32'd0);
      if (i == 0) cfg_write(8'd1, 8'd0);
      else        tick();
    end

    // Asynchronous reset mid-slot with a pending config write.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (i == 2) cfg_write(8'd6, 8'd2);
      else        tick();
    end
    check("async.pre_domain", 32'(domain), 32'd1);
    check("async.pre_slot_cnt", 32'(slot_cnt), 32'd2);
    #1 reset = 1'b1;
    #1;
    chk_pat("async", 1'b0, 1'b1, 0);
    check("async.slot_cnt", 32'(slot_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
    for (int i = 0; i <= 11; i++) begin
      chk_pat("postrst", dflt_dom[i % 8], dflt_act[i % 4], i / 8);
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  // The bench never waits on a DUT event, but a stuck run still ends here.
  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
